// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the result buffer of the matrix accelerator.
//   - rbuf_state_t      : APB read FSM states (IDLE / WAIT / RESP)
//   - RBUF_RESULT_ADDR  : default APB address that pops one result word
//   - RBUF_CNT_OFFSET   : byte offset of the occupancy register from RESULT_ADDR
//   - ACC_EN / ACC_END  : asserted level of a flag / value of the end-of-frame tag
package acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rbuf_state_t;

    localparam logic [11:0] RBUF_RESULT_ADDR = 12'h010;
    localparam int          RBUF_CNT_OFFSET  = 4;

    localparam logic ACC_EN  = 1'b1;
    localparam logic ACC_END = 1'b1;

endpackage

// File: rtl/acc_rbuf_fifo.sv
// acc_rbuf_fifo: synchronous FIFO holding {last, data} result entries.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data,    write request; ignored while full
//   push_last
//   pop                 read request; ignored while empty
//   head_data,          entry at the read pointer (first-word fall-through)
//   head_last
//   empty, full         status derived from the registered pointers only
//   count               number of stored entries
module acc_rbuf_fifo
    import acc_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              empty,
    output logic              full,
    output logic [PTR_W-1:0]  count
);

    localparam int ADDR_W = PTR_W - 1;

    logic [DATA_W:0]      mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic                 do_push;
    logic                 do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[ADDR_W-1:0]] <= {push_last, push_data};
    end

    // Head is read straight from storage so the APB side can pop and capture
    // the word on the same edge.
    assign {head_last, head_data} = mem[rd_ptr_reg[ADDR_W-1:0]];

endmodule

// File: rtl/acc_result_buffer.sv
// acc_result_buffer: collects result words from the compute core in a FIFO and
// returns them to the CPU, one word per APB read of RESULT_ADDR.
// Optional feature macro: ACC_RBUF_CNT_REG_EN (occupancy readable at RESULT_ADDR+4).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   res_valid/res_data/      compute-side push handshake; res_last tags the
//   res_last/res_ready       final word of a frame; res_ready = !full
//   PSEL/PENABLE/PWRITE/     APB completer interface; reads of an empty FIFO
//   PADDR/PRDATA/PREADY/     stall up to WAIT_MAX cycles then error out
//   PSLVERR
//   buf_empty, buf_full      FIFO status
//   frame_done               one-cycle pulse when a last-tagged word is returned
module acc_result_buffer
    import acc_pkg::*;
#(
    parameter int                        DATA_W         = 32,
    parameter int                        DEPTH          = 16,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] RESULT_ADDR    = APB_ADDR_WIDTH'(RBUF_RESULT_ADDR),
    parameter int                        WAIT_MAX       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      res_valid,
    input  logic [DATA_W-1:0]         res_data,
    input  logic                      res_last,
    output logic                      res_ready,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      buf_empty,
    output logic                      buf_full,
    output logic                      frame_done
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(WAIT_MAX) + 1;

    rbuf_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0]       prdata_reg, prdata_next;
    logic              pready_reg, pready_next;
    logic              pslverr_reg, pslverr_next;
    logic              frame_done_reg, frame_done_next;

    logic              fifo_pop;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic              fifo_empty;
    logic              fifo_full;
    logic [PTR_W-1:0]  occupancy;
    logic              access;

    acc_rbuf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (res_valid),
        .push_data (res_data),
        .push_last (res_last),
        .pop       (fifo_pop),
        .head_data (head_data),
        .head_last (head_last),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (occupancy)
    );

`ifdef ACC_RBUF_CNT_REG_EN
    localparam logic [APB_ADDR_WIDTH-1:0] CNT_ADDR =
        RESULT_ADDR + APB_ADDR_WIDTH'(RBUF_CNT_OFFSET);
`else
    logic unused_occupancy;
    assign unused_occupancy = ^occupancy;
`endif

    // The !PREADY term keeps the completing cycle from being decoded again.
    assign access = PSEL && PENABLE && !pready_reg;

    always_comb begin
        state_next      = state_reg;
        wait_cnt_next   = wait_cnt_reg;
        prdata_next     = prdata_reg;
        pslverr_next    = pslverr_reg;
        frame_done_next = 1'b0;
        fifo_pop        = 1'b0;
        pready_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (access) begin
                    if (PWRITE) begin
                        pslverr_next = 1'b1;
                        state_next   = ST_RESP;
                    end else if (PADDR == RESULT_ADDR) begin
                        if (!fifo_empty) begin
                            fifo_pop        = 1'b1;
                            prdata_next     = 32'(head_data);
                            frame_done_next = (head_last == ACC_END) ? ACC_EN : 1'b0;
                            state_next      = ST_RESP;
                        end else begin
                            wait_cnt_next = '0;
                            state_next    = ST_WAIT;
                        end
`ifdef ACC_RBUF_CNT_REG_EN
                    end else if (PADDR == CNT_ADDR) begin
                        prdata_next = 32'(occupancy);
                        state_next  = ST_RESP;
`endif
                    end else begin
                        prdata_next  = '0;
                        pslverr_next = 1'b1;
                        state_next   = ST_RESP;
                    end
                end
            end

            ST_WAIT: begin
                if (!PSEL) begin
                    // Master abandoned the transfer; nothing is popped.
                    state_next = ST_IDLE;
                end else if (!fifo_empty) begin
                    fifo_pop        = 1'b1;
                    prdata_next     = 32'(head_data);
                    frame_done_next = (head_last == ACC_END) ? ACC_EN : 1'b0;
                    state_next      = ST_RESP;
                end else if (wait_cnt_reg == CNT_W'(WAIT_MAX - 1)) begin
                    prdata_next  = '0;
                    pslverr_next = 1'b1;
                    state_next   = ST_RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + CNT_W'(1);
                end
            end

            ST_RESP: begin
                prdata_next  = '0;
                pslverr_next = 1'b0;
                state_next   = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // PREADY is high exactly while the FSM sits in RESP.
        pready_next = (state_next == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            wait_cnt_reg   <= '0;
            prdata_reg     <= '0;
            pready_reg     <= 1'b0;
            pslverr_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            prdata_reg     <= prdata_next;
            pready_reg     <= pready_next;
            pslverr_reg    <= pslverr_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign PRDATA     = prdata_reg;
    assign PREADY     = pready_reg;
    assign PSLVERR    = pslverr_reg;
    assign frame_done = frame_done_reg;
    assign res_ready  = !fifo_full;
    assign buf_empty  = fifo_empty;
    assign buf_full   = fifo_full;

endmodule
